// File: rtl/finalsoc_leds_pkg.sv
// Shared types and constants for the LED PIO arbiter and its round-robin picker.
package finalsoc_leds_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_HOLD  = 2'd3
  } leds_state_t;

  localparam int LEDS_LED_W = 14;

  localparam logic [1:0] LEDS_PIO_DATA_ADDR = 2'd0;

endpackage

// File: rtl/finalsoc_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module finalsoc_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [PTR_W-1:0]   grant,
  output logic               any_req
);

  always_comb begin
    int idx;
    logic [PTR_W-1:0] sel;
    grant   = '0;
    any_req = 1'b0;
    idx     = 0;
    sel     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sel = PTR_W'(idx);
      if (!any_req && req[sel]) begin
        grant   = sel;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/finalsoc_leds_arbiter.sv
// Round-robin write sequencer sharing the LED PIO among NUM_REQ requesters.
// Define LEDS_ARB_READBACK_EN to add a readback/compare cycle after each write.
module finalsoc_leds_arbiter
  import finalsoc_leds_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int LED_W       = LEDS_LED_W,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*LED_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]         ack,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic [1:0]                 avm_address,
  output logic                       avm_chipselect,
  output logic                       avm_write_n,
  output logic [31:0]                avm_writedata,
  input  logic [31:0]                avm_readdata,
  output logic                       err
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
`ifdef LEDS_ARB_READBACK_EN
  localparam leds_state_t ACK_ST = ST_READ;
`else
  localparam leds_state_t ACK_ST = ST_WRITE;
`endif

  leds_state_t      state, state_d;
  logic [PTR_W-1:0] ptr, ptr_d;
  logic [PTR_W-1:0] winner, winner_d;
  logic [PTR_W-1:0] last_grant_d;
  logic [LED_W-1:0] pattern, pattern_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [PTR_W-1:0] pick;
  logic             any_req;
  logic [LED_W-1:0] slices [NUM_REQ];
  logic             unused_readdata;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign slices[g] = req_data[g*LED_W +: LED_W];
  end

  finalsoc_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .req     (req),
    .ptr     (ptr),
    .grant   (pick),
    .any_req (any_req)
  );

  assign avm_address     = LEDS_PIO_DATA_ADDR;
  assign unused_readdata = ^avm_readdata;

  always_comb begin
    state_d      = state;
    ptr_d        = ptr;
    winner_d     = winner;
    last_grant_d = last_grant;
    pattern_d    = pattern;
    cnt_d        = cnt;
    case (state)
      ST_IDLE: begin
        if (any_req) begin
          state_d      = ST_WRITE;
          winner_d     = pick;
          last_grant_d = pick;
          pattern_d    = slices[pick];
          ptr_d        = (pick == PTR_W'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
        end
      end
      ST_WRITE: begin
`ifdef LEDS_ARB_READBACK_EN
        state_d = ST_READ;
`else
        if (HOLD_CYCLES > 0) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_INIT;
        end else begin
          state_d = ST_IDLE;
        end
`endif
      end
      ST_READ: begin
        if (HOLD_CYCLES > 0) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_INIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (cnt == '0) state_d = ST_IDLE;
        else           cnt_d   = cnt - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus strobes, ack and busy are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      ptr            <= '0;
      winner         <= '0;
      last_grant     <= '0;
      pattern        <= '0;
      cnt            <= '0;
      ack            <= '0;
      busy           <= 1'b0;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_writedata  <= '0;
    end else begin
      state          <= state_d;
      ptr            <= ptr_d;
      winner         <= winner_d;
      last_grant     <= last_grant_d;
      pattern        <= pattern_d;
      cnt            <= cnt_d;
      ack            <= (state_d == ACK_ST) ? (NUM_REQ'(1) << winner_d) : '0;
      busy           <= (state_d != ST_IDLE);
      avm_chipselect <= (state_d == ST_WRITE) || (state_d == ST_READ);
      avm_write_n    <= (state_d != ST_WRITE);
      avm_writedata  <= 32'(pattern_d);
    end
  end

`ifdef LEDS_ARB_READBACK_EN
  // PIO readdata reflects its output register combinationally, so it is valid during READ.
  always_ff @(posedge clk) begin
    if (reset)
      err <= 1'b0;
    else if ((state == ST_READ) && (avm_readdata[LED_W-1:0] != pattern))
      err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_finalsoc_leds_arbiter.sv
// Scoreboard bench for finalsoc_leds_arbiter: directed requests push expected writes,
// a negedge monitor pops and checks every PIO write and every ack cycle.
module tb_finalsoc_leds_arbiter;

  localparam int NUM_REQ = 4;
  localparam int LED_W   = 14;
  localparam int HOLD    = 4;
`ifdef LEDS_ARB_READBACK_EN
  localparam int SPACING  = 3 + HOLD;
  localparam int BUSY_LEN = 2 + HOLD;
`else
  localparam int SPACING  = 2 + HOLD;
  localparam int BUSY_LEN = 1 + HOLD;
`endif

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic [NUM_REQ-1:0]       req = '0;
  logic [NUM_REQ*LED_W-1:0] req_data = '0;
  logic [NUM_REQ-1:0]       ack;
  logic                     busy;
  logic [1:0]               last_grant;
  logic [1:0]               avm_address;
  logic                     avm_chipselect;
  logic                     avm_write_n;
  logic [31:0]              avm_writedata;
  logic [31:0]              avm_readdata;
  logic                     err;

  logic [13:0] pio_reg = '0;
  bit          corrupt = 1'b0;

  typedef struct {
    int          idx;
    logic [13:0] data;
    int          gap;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   last_wr = 0;
  int   rd_pending = -1;

  finalsoc_leds_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .LED_W       (LED_W),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req            (req),
    .req_data       (req_data),
    .ack            (ack),
    .busy           (busy),
    .last_grant     (last_grant),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_write_n    (avm_write_n),
    .avm_writedata  (avm_writedata),
    .avm_readdata   (avm_readdata),
    .err            (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // PIO slave model; optionally corrupts one pattern to exercise readback.
  always @(posedge clk)
    if (avm_chipselect && !avm_write_n)
      pio_reg <= (corrupt && avm_writedata[13:0] == 14'h1234) ? 14'h0000 : avm_writedata[13:0];
  assign avm_readdata = {18'b0, pio_reg};

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [13:0] data, input int gap);
    exp_t e;
    e.idx  = idx;
    e.data = data;
    e.gap  = gap;
    sb.push_back(e);
  endtask

  task automatic setData(input int idx, input logic [13:0] data);
    req_data[idx*LED_W +: LED_W] = data;
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL drain_timeout: %0d writes pending, want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle_reached", 32'(busy), 32'd0);
  endtask

  always @(negedge clk) begin
    exp_t       e;
    logic [3:0] want_ack;
    if (reset) begin
      rd_pending = -1;
    end else begin
      want_ack = '0;
`ifdef LEDS_ARB_READBACK_EN
      if (rd_pending >= 0) begin
        want_ack   = 4'(1 << rd_pending);
        rd_pending = -1;
      end
`endif
      if (avm_chipselect && !avm_write_n) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_write: got data %0h, want no write", avm_writedata);
        end else begin
          e = sb.pop_front();
          checkOutput("writedata", avm_writedata, 32'(e.data));
          checkOutput("address", 32'(avm_address), 32'd0);
          checkOutput("last_grant", 32'(last_grant), 32'(e.idx));
          if (e.gap > 0) checkOutput("spacing", 32'(cyc - last_wr), 32'(e.gap));
`ifdef LEDS_ARB_READBACK_EN
          rd_pending = e.idx;
`else
          want_ack = 4'(1 << e.idx);
`endif
        end
        last_wr = cyc;
      end
      checkOutput("ack", 32'(ack), 32'(want_ack));
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int busy_cnt;
    int ack_cnt;

    // Reset with all requesters active.
    req = 4'b1111;
    setData(0, 14'h0111);
    setData(1, 14'h0222);
    setData(2, 14'h2AAA);
    setData(3, 14'h3C3C);
    repeat (3) @(negedge clk);
    checkOutput("rst_chipselect", 32'(avm_chipselect), 32'd0);
    checkOutput("rst_write_n", 32'(avm_write_n), 32'd1);
    checkOutput("rst_ack", 32'(ack), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_last_grant", 32'(last_grant), 32'd0);
    checkOutput("rst_writedata", avm_writedata, 32'd0);
    applyStimulus(0, 14'h0111, 0);
    reset = 1'b0;
    checkOutput("cycle1_write_n", 32'(avm_write_n), 32'd1);
    @(negedge clk);
    checkOutput("cycle2_write_n", 32'(avm_write_n), 32'd0);
    req = '0;

    // Single request, busy length and single ack.
    waitIdle(20);
    req = 4'b0100;
    applyStimulus(2, 14'h2AAA, 0);
    busy_cnt = 0;
    ack_cnt  = 0;
    repeat (12) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (ack[2]) begin
        ack_cnt++;
        req = '0;
      end
    end
    checkOutput("busy_len", 32'(busy_cnt), 32'(BUSY_LEN));
    checkOutput("ack2_count", 32'(ack_cnt), 32'd1);

    // Round robin over 0,1,3 from a fresh pointer.
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    req = 4'b1011;
    applyStimulus(0, 14'h0111, 0);
    applyStimulus(1, 14'h0222, SPACING);
    applyStimulus(3, 14'h3C3C, SPACING);
    applyStimulus(0, 14'h0111, SPACING);
    applyStimulus(1, 14'h0222, SPACING);
    applyStimulus(3, 14'h3C3C, SPACING);
    waitDrain(80);
    req = '0;

    // Data changed right after grant must not affect the write.
    waitIdle(20);
    setData(1, 14'h0001);
    req = 4'b0010;
    applyStimulus(1, 14'h0001, 0);
    @(posedge clk);
    #1 setData(1, 14'h3FFF);
    waitDrain(20);
    req = '0;

    // Reset during HOLD clears pointer and last_grant.
    waitIdle(20);
    setData(1, 14'h0222);
    req = 4'b0100;
    applyStimulus(2, 14'h2AAA, 0);
    waitDrain(20);
    req = '0;
    repeat (2) @(negedge clk);
    checkOutput("busy_in_hold", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("hold_rst_busy", 32'(busy), 32'd0);
    checkOutput("hold_rst_write_n", 32'(avm_write_n), 32'd1);
    checkOutput("hold_rst_chipselect", 32'(avm_chipselect), 32'd0);
    checkOutput("hold_rst_ack", 32'(ack), 32'd0);
    checkOutput("hold_rst_last_grant", 32'(last_grant), 32'd0);
    reset = 1'b0;
    req = 4'b1010;
    applyStimulus(1, 14'h0222, 0);
    applyStimulus(3, 14'h3C3C, SPACING);
    waitDrain(40);
    req = '0;

`ifdef LEDS_ARB_READBACK_EN
    // Readback mismatch sets a sticky err.
    waitIdle(20);
    corrupt = 1'b1;
    setData(0, 14'h1234);
    req = 4'b0001;
    applyStimulus(0, 14'h1234, 0);
    waitDrain(20);
    req = '0;
    repeat (2) @(negedge clk);
    checkOutput("err_set", 32'(err), 32'd1);
    repeat (6) @(negedge clk);
    checkOutput("err_sticky", 32'(err), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("err_cleared", 32'(err), 32'd0);
    corrupt = 1'b0;
`else
    checkOutput("err_tied", 32'(err), 32'd0);
`endif

    waitIdle(20);
    repeat (8) @(negedge clk);
    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/finalsoc_leds_arbiter.md
Name: finalsoc_leds_arbiter

Overview:
- Round-robin arbiter and write sequencer that shares the 14-bit LED PIO register among NUM_REQ on-chip requesters, e.g. voice-activity display, VU meter and debug status.
- Acts as the single Avalon-MM master on the LED PIO slave port.
- Issues one-cycle writes to register offset 0.
- Enforces a minimum display hold time between successive updates.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- LED_W, 14, LED pattern width; must equal the PIO data width.
- HOLD_CYCLES, 4, idle cycles after each write before the next grant; 0 means no hold.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester request level.
- req_data  in  NUM_REQ*LED_W  pattern for requester i, in bits [i*LED_W +: LED_W].
- ack  out  NUM_REQ  one-cycle completion pulse per requester.
- busy  out  1  high whenever the FSM is not in IDLE.
- last_grant  out  $clog2(NUM_REQ)  index of the most recently served requester.
- avm_address  out  2  PIO register offset; always 0.
- avm_chipselect  out  1  PIO chipselect.
- avm_write_n  out  1  PIO active-low write strobe.
- avm_writedata  out  32  zero-extended pattern.
- avm_readdata  in  32  PIO readdata; used only with the optional feature.
- err  out  1  sticky readback-mismatch flag; tied to 0 without the feature.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port reset.
- Reset values:
  - FSM in IDLE; all ack bits 0; busy 0; last_grant 0.
  - avm_chipselect 0, avm_write_n 1, avm_writedata 0, avm_address 0; err 0.
  - Round-robin pointer 0, so requester 0 has first priority.
  - Reset asserted mid-transaction aborts immediately. No ack is issued and the PIO keeps whatever value it last latched.
- All outputs are registered.
- FSM states: IDLE, WRITE, READ (feature only), HOLD.
- IDLE:
  - If any req bit is set, grant the first set bit searching upward from the pointer, wrapping modulo NUM_REQ.
  - Capture that requester's req_data slice into a pattern register.
  - Set last_grant to the winner and the pointer to (winner+1) mod NUM_REQ.
  - Go to WRITE. The grant decision takes 1 cycle.
- WRITE (exactly 1 cycle):
  - avm_chipselect=1, avm_write_n=0, avm_address=0, avm_writedata={18'b0, pattern}.
  - Without the feature, ack[winner]=1 in this same cycle.
  - Next state: HOLD if HOLD_CYCLES>0, otherwise IDLE.
- HOLD:
  - Count down from HOLD_CYCLES-1 to 0, then go to IDLE.
  - avm_chipselect=0, avm_write_n=1.
- Update spacing: back-to-back updates are spaced 2+HOLD_CYCLES cycles apart.
- Request rules:
  - req_data is sampled only at the grant cycle; later changes do not affect the write in flight.
  - A requester must hold req until it sees ack.
  - Dropping req before a grant silently withdraws the request.
  - req still high on the cycle after ack counts as a new request, arbitrated behind the other pending requesters.
- Simultaneous requests: served strictly round-robin; no requester is served twice while another is pending.
- Idle conditions: no requests means the FSM stays in IDLE with the bus idle. A single persistent requester is re-served every 2+HOLD_CYCLES cycles.

Optional Feature:
- Macro: LEDS_ARB_READBACK_EN.
- When defined, WRITE is followed by READ (1 cycle):
  - avm_chipselect=1, avm_write_n=1, avm_address=0.
  - avm_readdata[LED_W-1:0] is compared with the pattern register. The PIO readdata is combinational from its output register, so it is valid in this same cycle.
  - ack[winner] pulses in READ instead of WRITE.
  - A mismatch sets err, which clears only on reset.
  - Update spacing becomes 3+HOLD_CYCLES cycles.
- When undefined: no READ state, avm_readdata ignored, err constant 0.

Decomposition:
- Shared package finalsoc_leds_pkg:
  - FSM state enum (IDLE, WRITE, READ, HOLD).
  - LED_W default.
  - PIO register offset constant LEDS_PIO_DATA_ADDR=0.
- One natural sub-module, finalsoc_rr_arbiter: combinational round-robin priority picker.
  - Inputs: req vector, pointer.
  - Outputs: grant index and any_req.
  - Reusable for other shared PIOs.

Test Plan:
- Reset with req=4'b1111 held through reset: no bus activity and no ack during reset. First write after release is requester 0's data, with avm_write_n low on cycle 2 after release.
- req[2]=1, data 14'h2AAA, HOLD_CYCLES=4: one write of writedata 32'h00002AAA; ack[2] pulses once in the write cycle; busy high for 5 cycles.
- req=4'b1011 held continuously: grant order 0,1,3,0,1,3; writes spaced exactly 6 cycles apart; last_grant tracks the order.
- req[1] asserted, req_data changed from 14'h0001 to 14'h3FFF on the cycle after grant: writedata is 32'h00000001.
- Reset asserted during HOLD: FSM returns to IDLE, pointer returns to 0, no ack emitted, avm_write_n=1 on the next cycle.
- With LEDS_ARB_READBACK_EN, PIO model forced to return 14'h0000 when 14'h1234 is written: err rises in the READ cycle and stays high until reset; ack still pulses.
